// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-addressable data memory.
// Used by both the load and store paths.
package mem_pkg;

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;

    localparam logic [31:0] MEM_OFFSET = 32'h8002_0000;
    localparam int          MEM_SIZE   = 1048577;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        RESP
    } mem_state_e;

    function automatic logic [2:0] acc_bytes(input logic [1:0] size);
        case (size)
            ACC_HALF: acc_bytes = 3'd2;
            ACC_WORD: acc_bytes = 3'd4;
            default:  acc_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of little-endian assembled load data.
// Shared with the writeback stage.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ext
);

    always_comb begin
        ext = 32'h0;
        case (size)
            ACC_BYTE: ext = {{24{sgn & data[7]}}, data[7:0]};
            ACC_HALF: ext = {{16{sgn & data[15]}}, data[15:0]};
            ACC_WORD: ext = data;
            default:  ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_read_unit.sv
// Load unit: byte-serial reads through a registered memory port,
// little-endian assembly, extension and a valid/ready response.
module mem_read_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] OFFSET = MEM_OFFSET,
    parameter int          SIZE   = MEM_SIZE,
    parameter int          IDX_W  = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_access_size,
    input  logic             req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_error,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_rd_addr,
    input  logic [7:0]       mem_rd_data
);

    mem_state_e  state;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  cnt;
    logic [1:0]  last;
    logic [31:0] data_q;

    logic [32:0] addr33;
    logic [32:0] idx33;
    logic [2:0]  nb;
    logic        misalign;
    logic        bad;
    logic [1:0]  prv;
    logic [31:0] asm_data;
    logic [31:0] ext;

    assign req_ready = (state == IDLE);

    // 33-bit arithmetic so addresses below OFFSET never wrap into range
    assign addr33   = {1'b0, req_addr};
    assign idx33    = addr33 - {1'b0, OFFSET};
    assign nb       = acc_bytes(req_access_size);
    assign misalign = ((req_access_size == ACC_WORD) && (req_addr[1:0] != 2'b00))
                   || ((req_access_size == ACC_HALF) && req_addr[0]);
    assign bad      = (addr33 < {1'b0, OFFSET})
                   || (req_access_size == 2'b11)
                   || ((idx33 + {30'b0, nb}) > 33'(SIZE))
                   || misalign;

    assign prv = cnt - 2'd1;

    // Final byte arrives during DRAIN; merge it before extending
    always_comb begin
        asm_data = data_q;
        asm_data[{cnt, 3'b000} +: 8] = mem_rd_data;
    end

    load_extend u_ext (
        .data (asm_data),
        .size (size_q),
        .sgn  (sgn_q),
        .ext  (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            size_q      <= ACC_BYTE;
            sgn_q       <= 1'b0;
            cnt         <= 2'd0;
            last        <= 2'd0;
            data_q      <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'h0;
            rsp_error   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q <= req_access_size;
                        sgn_q  <= req_signed;
                        cnt    <= 2'd0;
                        last   <= 2'(nb - 3'd1);
                        data_q <= 32'h0;
                        if (bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_data  <= 32'h0;
                        end else begin
                            state       <= ISSUE;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= idx33[IDX_W-1:0];
                        end
                    end
                end
                ISSUE: begin
                    if (cnt != 2'd0)
                        data_q[{prv, 3'b000} +: 8] <= mem_rd_data;
                    if (cnt == last) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        cnt         <= cnt + 2'd1;
                        mem_rd_addr <= mem_rd_addr + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    rsp_data  <= ext;
                    rsp_error <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_data  <= 32'h0;
                        rsp_error <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_unit.sv
// Directed bench for mem_read_unit with a registered byte memory model.
module tb_mem_read_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_access_size;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        mem_rd_en;
    logic [20:0] mem_rd_addr;
    logic [7:0]  mem_rd_data;

    int vectors;
    int miscompares;
    int rd_cnt;
    int addrq[$];
    logic [7:0] mem [int];

    mem_read_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_access_size (req_access_size),
        .req_signed      (req_signed),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_error       (rsp_error),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            rd_cnt++;
            addrq.push_back(int'(mem_rd_addr));
            mem_rd_data <= mem.exists(int'(mem_rd_addr)) ?
                           mem[int'(mem_rd_addr)] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic [1:0] sz,
                          input logic s, output logic [31:0] d,
                          output logic e, output int lat, output int pulses);
        rd_cnt = 0;
        addrq.delete();
        req_addr        = a;
        req_access_size = sz;
        req_signed      = s;
        req_valid       = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        d      = rsp_data;
        e      = rsp_error;
        pulses = rd_cnt;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_clr"}, rsp_data, 32'h0);
    endtask

    task automatic run_ok(input string tag, input logic [31:0] a,
                          input logic [1:0] sz, input logic s,
                          input logic [31:0] exp, input int exp_lat);
        logic [31:0] d;
        logic e;
        int lat;
        int p;
        do_req(a, sz, s, d, e, lat, p);
        check({tag, "_data"}, d, exp);
        check({tag, "_err"}, 32'(e), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        finish_rsp(tag);
    endtask

    task automatic run_err(input string tag, input logic [31:0] a,
                           input logic [1:0] sz);
        logic [31:0] d;
        logic e;
        int lat;
        int p;
        do_req(a, sz, 1'b0, d, e, lat, p);
        check({tag, "_data"}, d, 32'h0);
        check({tag, "_err"}, 32'(e), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_rden"}, 32'(p), 32'd0);
        finish_rsp(tag);
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        int lat;
        int p;
        logic [31:0] held;
        int seen;

        vectors = 0;
        miscompares = 0;
        rd_cnt = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'h0;
        req_access_size = 2'b00;
        req_signed = 1'b0;
        rsp_ready = 1'b0;

        mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'hF0;
        mem[6] = 8'h34; mem[7] = 8'h82;
        mem[32'h0010_0000] = 8'h5A;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_data", rsp_data, 32'h0);
        check("rst_err", 32'(rsp_error), 32'd0);
        check("rst_rden", 32'(mem_rd_en), 32'd0);
        check("rst_rdaddr", 32'(mem_rd_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_ready", 32'(req_ready), 32'd1);

        // Word read with address sequence
        do_req(32'h8002_0000, 2'b10, 1'b0, d, e, lat, p);
        check("word_data", d, 32'h1234_5678);
        check("word_err", 32'(e), 32'd0);
        check("word_lat", 32'(lat), 32'd6);
        check("word_pulses", 32'(p), 32'd4);
        for (int i = 0; i < 4; i++)
            check("word_rdaddr", 32'(addrq.size() > i ? addrq[i] : -1), 32'(i));
        finish_rsp("word");

        run_ok("byte_s", 32'h8002_0004, 2'b00, 1'b1, 32'hFFFF_FFF0, 3);
        run_ok("byte_u", 32'h8002_0004, 2'b00, 1'b0, 32'h0000_00F0, 3);
        run_ok("half_s", 32'h8002_0006, 2'b01, 1'b1, 32'hFFFF_8234, 4);
        run_ok("half_u", 32'h8002_0006, 2'b01, 1'b0, 32'h0000_8234, 4);
        run_ok("word_sgn", 32'h8002_0000, 2'b10, 1'b1, 32'h1234_5678, 6);
        run_ok("top_byte", 32'h8012_0000, 2'b00, 1'b0, 32'h0000_005A, 3);

        run_err("e_below", 32'h8001_FFFC, 2'b10);
        run_err("e_align", 32'h8002_0002, 2'b10);
        run_err("e_size", 32'h8002_0000, 2'b11);
        run_err("e_top", 32'h8012_0000, 2'b10);
        run_err("e_half_al", 32'h8002_0005, 2'b01);
        run_err("e_half_top", 32'h8012_0000, 2'b01);

        // Backpressure: response held stable while rsp_ready is low
        do_req(32'h8002_0006, 2'b01, 1'b1, d, e, lat, p);
        check("bp_data", d, 32'hFFFF_8234);
        held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold", rsp_data, held);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        finish_rsp("bp");

        // Reset in the second ISSUE cycle of a word read
        req_addr = 32'h8002_0000;
        req_access_size = 2'b10;
        req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("ab_rden_on", 32'(mem_rd_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ab_rden_off", 32'(mem_rd_en), 32'd0);
        check("ab_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (rsp_valid) seen++;
        end
        check("ab_no_rsp", 32'(seen), 32'd0);
        check("ab_ready", 32'(req_ready), 32'd1);
        run_ok("ab_word", 32'h8002_0000, 2'b10, 1'b0, 32'h1234_5678, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
